// File: rtl/serdes_align_pkg.sv
// Shared types and defaults for the per-lane SERDES word aligner.
// Holds the FSM state encoding and the default tuning constants.
package serdes_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    SLIP,
    SETTLE,
    LOCKED,
    FAIL
  } align_state_e;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_LOCK_COUNT    = 16;
  localparam int DEF_UNLOCK_COUNT  = 4;
  localparam int DEF_MAX_SLIPS     = 8;

  localparam int SLIP_W = 4;

endpackage

// File: rtl/serdes_lane_aligner.sv
// Per-lane word aligner: bitslips the ISERDES until the training word matches.
// Define SERDES_LANE_ALIGNER_STATS_EN to add the o_err_count locked-error counter.
module serdes_lane_aligner
  import serdes_align_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
  parameter int MAX_SLIPS     = DEF_MAX_SLIPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_train,
  input  logic [7:0]        i_pattern,
  input  logic [7:0]        i_lvds,
  output logic              o_bitslip,
  output logic              o_aligned,
  output logic              o_fail,
  output logic [SLIP_W-1:0] o_slip_count
`ifdef SERDES_LANE_ALIGNER_STATS_EN
  ,
  output logic [15:0]       o_err_count
`endif
);

  localparam logic [7:0]        LOCK_V   = 8'(LOCK_COUNT);
  localparam logic [3:0]        UNLOCK_V = 4'(UNLOCK_COUNT);
  localparam logic [3:0]        SETTLE_V = 4'(SETTLE_CYCLES);
  localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(MAX_SLIPS);

  align_state_e      state_q, state_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic              bitslip_q, bitslip_d;
  logic              aligned_q, aligned_d;
  logic              fail_q, fail_d;
  logic              hit;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
  logic [15:0]       err_cnt_q, err_cnt_d;
`endif

  assign hit = (i_lvds == i_pattern);

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    settle_cnt_d = settle_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    bitslip_d    = 1'b0;
    aligned_d    = aligned_q;
    fail_d       = fail_q;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    err_cnt_d    = err_cnt_q;
`endif
    if (!i_enable) begin
      state_d      = IDLE;
      match_cnt_d  = '0;
      miss_cnt_d   = '0;
      settle_cnt_d = '0;
      slip_cnt_d   = '0;
      aligned_d    = 1'b0;
      fail_d       = 1'b0;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
      err_cnt_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          match_cnt_d  = '0;
          miss_cnt_d   = '0;
          settle_cnt_d = '0;
          slip_cnt_d   = '0;
          aligned_d    = 1'b0;
          fail_d       = 1'b0;
          state_d      = COMPARE;
        end
        COMPARE: begin
          if (i_train) begin
            if (hit) begin
              match_cnt_d = match_cnt_q + 8'd1;
              if (match_cnt_q == LOCK_V - 8'd1) begin
                state_d    = LOCKED;
                aligned_d  = 1'b1;
                miss_cnt_d = '0;
              end
            end else begin
              match_cnt_d = '0;
              if (slip_cnt_q == SLIP_MAX) begin
                state_d = FAIL;
                fail_d  = 1'b1;
              end else begin
                state_d   = SLIP;
                bitslip_d = 1'b1;
              end
            end
          end
        end
        SLIP: begin
          if (slip_cnt_q != '1) slip_cnt_d = slip_cnt_q + 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
        SETTLE: begin
          // Runs regardless of i_train; ISERDES settling is time-based.
          if (settle_cnt_q == SETTLE_V - 4'd1) begin
            settle_cnt_d = '0;
            state_d      = COMPARE;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        LOCKED: begin
          if (i_train) begin
            if (hit) begin
              miss_cnt_d = '0;
            end else begin
`ifdef SERDES_LANE_ALIGNER_STATS_EN
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
`endif
              if (miss_cnt_q == UNLOCK_V - 4'd1) begin
                aligned_d   = 1'b0;
                slip_cnt_d  = '0;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
                state_d     = COMPARE;
              end else begin
                miss_cnt_d = miss_cnt_q + 4'd1;
              end
            end
          end
        end
        FAIL: begin
          fail_d    = 1'b1;
          aligned_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      fail_q       <= 1'b0;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      fail_q       <= fail_d;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign o_bitslip    = bitslip_q;
  assign o_aligned    = aligned_q;
  assign o_fail       = fail_q;
  assign o_slip_count = slip_cnt_q;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
  assign o_err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_serdes_lane_aligner.sv
// Bench for serdes_lane_aligner: ISERDES rotation model and lock timing.
// Expected timings are derived from slip/settle/lock arithmetic.
module tb_serdes_lane_aligner;
  import serdes_align_pkg::*;

  localparam int S = DEF_SETTLE_CYCLES;
  localparam int L = DEF_LOCK_COUNT;
  localparam int U = DEF_UNLOCK_COUNT;
  localparam int M = DEF_MAX_SLIPS;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       train;
  logic [7:0] pat;
  logic [7:0] lvds;
  logic       bitslip;
  logic       aligned;
  logic       fail;
  logic [3:0] slips;
`ifdef SERDES_LANE_ALIGNER_STATS_EN
  logic [15:0] errs;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serdes_lane_aligner dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (en),
    .i_train      (train),
    .i_pattern    (pat),
    .i_lvds       (lvds),
    .o_bitslip    (bitslip),
    .o_aligned    (aligned),
    .o_fail       (fail),
    .o_slip_count (slips)
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    ,
    .o_err_count  (errs)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] w;
    w = {v, v} << (k % 8);
    return w[15:8];
  endfunction

  function automatic logic [7:0] rand_pat();
    logic [7:0] p;
    bit sym;
    do begin
      p = 8'($urandom);
      sym = 1'b0;
      for (int k = 1; k < 8; k++) if (rotl(p, k) == p) sym = 1'b1;
    end while (sym);
    return p;
  endfunction

  task automatic idle_lane();
    en = 1'b0;
    train = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; train = 1'b0; pat = '0; lvds = '0;
    tick();
    tick();
    n_cmp++;
    if (bitslip !== 1'b0) begin n_bad++; $display("FAIL reset_bitslip got %b want 0", bitslip); end
    n_cmp++;
    if (aligned !== 1'b0) begin n_bad++; $display("FAIL reset_aligned got %b want 0", aligned); end
    n_cmp++;
    if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail got %b want 0", fail); end
    n_cmp++;
    if (slips !== 4'd0) begin n_bad++; $display("FAIL reset_slips got %0d want 0", slips); end
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    n_cmp++;
    if (errs !== 16'd0) begin n_bad++; $display("FAIL reset_errs got %0d want 0", errs); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_aligned_start();
    int n, pulses;
    idle_lane();
    pat = 8'hB9; lvds = 8'hB9; en = 1'b1;
    tick();
    n = 0; pulses = 0;
    while (aligned !== 1'b1 && n < 100) begin
      if (bitslip) pulses++;
      tick();
      n++;
    end
    n_cmp++;
    if (n != L) begin n_bad++; $display("FAIL aligned_lock_time got %0d want %0d", n, L); end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL aligned_pulses got %0d want 0", pulses); end
    n_cmp++;
    if (slips !== 4'd0) begin n_bad++; $display("FAIL aligned_slips got %0d want 0", slips); end
  endtask

  task automatic test_misaligned();
    int off0, off, n, pulses, last, minsp, want;
    for (int t = 0; t < 3; t++) begin
      off0 = (t == 0) ? 3 : int'($urandom_range(1, 7));
      idle_lane();
      pat = rand_pat(); off = off0; lvds = rotl(pat, off); en = 1'b1;
      tick();
      n = 0; pulses = 0; last = -1; minsp = 1000;
      while (aligned !== 1'b1 && n < 500) begin
        if (bitslip) begin
          if (pulses > 0 && n - last < minsp) minsp = n - last;
          last = n;
          pulses++;
          off = (off + 7) % 8;
          lvds = rotl(pat, off);
        end
        tick();
        n++;
      end
      want = off0 * (S + 2) + L;
      n_cmp++;
      if (pulses != off0) begin n_bad++; $display("FAIL mis_pulses off=%0d got %0d want %0d", off0, pulses, off0); end
      n_cmp++;
      if (n != want) begin n_bad++; $display("FAIL mis_lock_time off=%0d got %0d want %0d", off0, n, want); end
      n_cmp++;
      if (slips !== 4'(off0)) begin n_bad++; $display("FAIL mis_slips got %0d want %0d", slips, off0); end
      if (off0 > 1) begin
        n_cmp++;
        if (minsp < S + 2) begin n_bad++; $display("FAIL mis_spacing got %0d want >=%0d", minsp, S + 2); end
      end
    end
  endtask

  task automatic test_never_match();
    int n, pulses, last, want;
    idle_lane();
    pat = rand_pat(); lvds = 8'h00; en = 1'b1;
    tick();
    n = 0; pulses = 0; last = -100;
    while (fail !== 1'b1 && n < 300) begin
      if (bitslip) begin pulses++; last = n; end
      // i_train drops across every settle window
      train = (pulses > 0 && n - last <= S) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    want = M * (S + 2) + 1;
    n_cmp++;
    if (n != want) begin n_bad++; $display("FAIL nm_fail_time got %0d want %0d", n, want); end
    n_cmp++;
    if (pulses != M) begin n_bad++; $display("FAIL nm_pulses got %0d want %0d", pulses, M); end
    n_cmp++;
    if (aligned !== 1'b0) begin n_bad++; $display("FAIL nm_aligned got %b want 0", aligned); end
    train = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bitslip) pulses++;
    end
    n_cmp++;
    if (pulses != M || fail !== 1'b1) begin
      n_bad++; $display("FAIL nm_sticky got pulses=%0d fail=%b want %0d/1", pulses, fail, M);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (fail !== 1'b0) begin n_bad++; $display("FAIL nm_fail_clear got %b want 0", fail); end
    n_cmp++;
    if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL nm_idle got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_loss_of_lock();
    int n;
    bit held, early;
    idle_lane();
    pat = rand_pat(); lvds = pat; en = 1'b1;
    tick();
    n = 0;
    while (aligned !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (aligned !== 1'b1) begin n_bad++; $display("FAIL lol_initial_lock got %b want 1", aligned); end
    held = 1'b1;
    for (int i = 0; i < U - 1; i++) begin
      lvds = pat ^ 8'($urandom_range(1, 255));
      tick();
      if (aligned !== 1'b1) held = 1'b0;
    end
    lvds = pat;
    tick();
    if (aligned !== 1'b1) held = 1'b0;
    n_cmp++;
    if (!held) begin n_bad++; $display("FAIL lol_hold got 0 want 1"); end
    early = 1'b0;
    for (int i = 0; i < U; i++) begin
      lvds = pat ^ 8'($urandom_range(1, 255));
      tick();
      if (i < U - 1 && aligned !== 1'b1) early = 1'b1;
    end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL lol_early_drop got 1 want 0"); end
    n_cmp++;
    if (aligned !== 1'b0) begin n_bad++; $display("FAIL lol_drop got %b want 0", aligned); end
    n_cmp++;
    if (slips !== 4'd0) begin n_bad++; $display("FAIL lol_slips got %0d want 0", slips); end
    lvds = pat;
    n = 0;
    while (aligned !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (n != L) begin n_bad++; $display("FAIL lol_relock got %0d want %0d", n, L); end
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    n_cmp++;
    if (errs !== 16'(2 * U - 1)) begin n_bad++; $display("FAIL lol_errs got %0d want %0d", errs, 2 * U - 1); end
`endif
  endtask

  task automatic test_train_gating();
    int drops, pulses;
    train = 1'b0; drops = 0; pulses = 0;
    repeat (1000) begin
      lvds = 8'($urandom);
      tick();
      if (aligned !== 1'b1) drops++;
      if (bitslip) pulses++;
    end
    n_cmp++;
    if (drops != 0) begin n_bad++; $display("FAIL gate_drops got %0d want 0", drops); end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL gate_pulses got %0d want 0", pulses); end
    train = 1'b1; lvds = pat;
    tick();
    n_cmp++;
    if (aligned !== 1'b1) begin n_bad++; $display("FAIL gate_after got %b want 1", aligned); end
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    n_cmp++;
    if (errs !== 16'(2 * U - 1)) begin n_bad++; $display("FAIL gate_errs got %0d want %0d", errs, 2 * U - 1); end
`endif
  endtask

  task automatic test_reset_mid_slip();
    int n;
    lvds = rotl(pat, 3);
    n = 0;
    while (bitslip !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++;
    if (bitslip !== 1'b1) begin n_bad++; $display("FAIL rs_slip_seen got %b want 1", bitslip); end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bitslip, aligned, fail} !== 3'b000) begin
      n_bad++; $display("FAIL rs_outputs got %b want 000", {bitslip, aligned, fail});
    end
    n_cmp++;
    if (slips !== 4'd0) begin n_bad++; $display("FAIL rs_slips got %0d want 0", slips); end
    n_cmp++;
    if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rs_idle got %0d want %0d", dut.state_q, IDLE); end
`ifdef SERDES_LANE_ALIGNER_STATS_EN
    n_cmp++;
    if (errs !== 16'd0) begin n_bad++; $display("FAIL rs_errs got %0d want 0", errs); end
`endif
    rst = 1'b0;
    en = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned_start();
    test_misaligned();
    test_never_match();
    test_loss_of_lock();
    test_train_gating();
    test_reset_mid_slip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
